// File: rtl/io_bus_responder.sv
// I/O window responder: UART TX FIFO, RX byte reads, cycle counter, program stop.
// Define IO_CYCLE_SNAPSHOT_EN to make 4-byte counter reads coherent.
module io_bus_responder #(
   parameter int TX_DEPTH_LOG2 = 4,
   parameter int FULL_MARGIN   = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] bus_a,
   input  logic [7:0]  bus_din,
   input  logic        bus_wr,
   output logic [7:0]  bus_dout,
   output logic        io_rd_sel,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_pop,
   output logic        prog_done,
   output logic        tx_overflow
);

   localparam int DEPTH = 1 << TX_DEPTH_LOG2;
   localparam int PW    = TX_DEPTH_LOG2;
   localparam int CW    = TX_DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);
   localparam logic [17:0] A_UART = 18'h30000;
   localparam logic [17:0] A_CNT  = 18'h30004;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      STOPPED
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [7:0]      bus_dout_q, bus_dout_d;
   logic            io_rd_sel_q, io_rd_sel_d;
   logic            rx_pop_q, rx_pop_d;
   logic            full_q, full_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
`ifdef IO_CYCLE_SNAPSHOT_EN
   logic [31:0]     snap_q, snap_d;
`endif

   logic            io_req, wr_req, rd_req;
   logic            is_uart, is_cnt, is_stop;
   logic            push_req, push, pop;
   logic [7:0]      push_byte;
   logic            unused_addr;

   function automatic logic [7:0] byte_sel(
      input logic [31:0] w,
      input logic [1:0]  s
   );
      logic [7:0] b;
      case (s)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   assign unused_addr = ^bus_a[31:18];
   assign io_req  = rdy_in & (bus_a[17:16] == 2'b11);
   assign wr_req  = io_req & bus_wr;
   assign rd_req  = io_req & ~bus_wr;
   assign is_uart = (bus_a[17:0] == A_UART);
   assign is_cnt  = (bus_a[17:2] == A_CNT[17:2]);
   assign is_stop = (bus_a[17:0] == A_CNT);

   assign tx_valid = (count_q != '0);
   assign tx_data  = mem_q[rd_ptr_q];
   assign pop      = tx_valid & tx_ready;

   always_comb begin
      push_req  = 1'b0;
      push_byte = 8'h00;
      state_d   = state_q;
      if (wr_req && state_q == RUN) begin
         if (is_uart && bus_din != 8'h00) begin
            push_req  = 1'b1;
            push_byte = bus_din;
         end else if (is_stop) begin
            // stop marker is the literal zero byte the zero-ignore rule filters
            push_req  = 1'b1;
            push_byte = 8'h00;
            state_d   = DRAIN;
         end
      end
      unique case (state_q)
         RUN:     ;
         DRAIN:   if (count_q == '0) state_d = STOPPED;
         STOPPED: state_d = STOPPED;
         default: state_d = RUN;
      endcase

      push = push_req & ((count_q != DEPTH_C) | pop);
      ovf_d = ovf_q | (push_req & ~push);

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_byte;
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      if (pop && !push) count_d = count_q - 1'b1;

      full_d = (state_d == STOPPED) |
               ((DEPTH_C - count_d) <= MARGIN_C);
      done_d = (state_d == STOPPED);

      cnt_d = rdy_in ? cnt_q + 32'd1 : cnt_q;

      bus_dout_d  = 8'h00;
      io_rd_sel_d = rd_req;
      rx_pop_d    = 1'b0;
`ifdef IO_CYCLE_SNAPSHOT_EN
      snap_d = snap_q;
`endif
      if (rd_req) begin
         if (is_uart) begin
            if (rx_valid) begin
               bus_dout_d = rx_data;
               rx_pop_d   = 1'b1;
            end
         end else if (is_cnt) begin
`ifdef IO_CYCLE_SNAPSHOT_EN
            if (bus_a[1:0] == 2'd0) begin
               snap_d     = cnt_q;
               bus_dout_d = cnt_q[7:0];
            end else begin
               bus_dout_d = byte_sel(snap_q, bus_a[1:0]);
            end
`else
            bus_dout_d = byte_sel(cnt_q, bus_a[1:0]);
`endif
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q     <= RUN;
         mem_q       <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cnt_q       <= '0;
         bus_dout_q  <= '0;
         io_rd_sel_q <= 1'b0;
         rx_pop_q    <= 1'b0;
         full_q      <= 1'b0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef IO_CYCLE_SNAPSHOT_EN
         snap_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cnt_q       <= cnt_d;
         bus_dout_q  <= bus_dout_d;
         io_rd_sel_q <= io_rd_sel_d;
         rx_pop_q    <= rx_pop_d;
         full_q      <= full_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
`ifdef IO_CYCLE_SNAPSHOT_EN
         snap_q      <= snap_d;
`endif
      end
   end

   assign bus_dout       = bus_dout_q;
   assign io_rd_sel      = io_rd_sel_q;
   assign rx_pop         = rx_pop_q;
   assign io_buffer_full = full_q;
   assign prog_done      = done_q;
   assign tx_overflow    = ovf_q;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: TX FIFO, reads, counter, stop, freeze.
module tb_io_bus_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [31:0] bus_a;
   logic [7:0]  bus_din;
   logic        bus_wr;
   logic [7:0]  bus_dout;
   logic        io_rd_sel;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        prog_done;
   logic        tx_overflow;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mcnt;
   logic [7:0]  txq[$];
   logic [31:0] snap;
   logic [7:0]  exp_b;

   io_bus_responder dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .bus_a          (bus_a),
      .bus_din        (bus_din),
      .bus_wr         (bus_wr),
      .bus_dout       (bus_dout),
      .io_rd_sel      (io_rd_sel),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_pop         (rx_pop),
      .prog_done      (prog_done),
      .tx_overflow    (tx_overflow)
   );

   always #5 clk_in = ~clk_in;

   // reference cycle counter
   always @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) mcnt <= '0;
      else if (rdy_in) mcnt <= mcnt + 32'd1;
   end

   // handshakes are stable mid-cycle; capture what the transmitter takes
   always @(negedge clk_in) begin
      if (rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: sim time expired, got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   task automatic idle();
      bus_a   = 32'h0;
      bus_wr  = 1'b0;
      bus_din = 8'h00;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      bus_a   = a;
      bus_wr  = 1'b1;
      bus_din = d;
      tick();
      idle();
   endtask

   task automatic chk_txq(input string tag,
                          input logic [7:0] e [$]);
      check({tag, "_n"}, txq.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         if (i < txq.size()) check({tag, "_b"}, txq[i], e[i]);
         else check({tag, "_b"}, 32'hFFFF, e[i]);
      end
      txq.delete();
   endtask

   initial begin
      rst_in   = 1'b0;
      rdy_in   = 1'b1;
      tx_ready = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      idle();
      repeat (3) tick();
      check("rst_dout", bus_dout, 0);
      check("rst_sel", io_rd_sel, 0);
      check("rst_full", io_buffer_full, 0);
      check("rst_txv", tx_valid, 0);
      check("rst_pop", rx_pop, 0);
      check("rst_done", prog_done, 0);
      check("rst_ovf", tx_overflow, 0);
      rst_in = 1'b1;
      tick();

      // zero bytes and stray I/O writes never reach the transmitter
      tx_ready = 1'b1;
      wr(32'h30000, 8'h41);
      wr(32'h30000, 8'h00);
      wr(32'h30008, 8'h33);
      wr(32'h30000, 8'h42);
      repeat (3) tick();
      chk_txq("tx_zero", '{8'h41, 8'h42});

      rx_valid = 1'b1;
      rx_data  = 8'h5A;
      bus_a    = 32'h30000;
      tick();
      idle();
      check("rx_dout", bus_dout, 8'h5A);
      check("rx_sel", io_rd_sel, 1);
      check("rx_pop", rx_pop, 1);
      rx_valid = 1'b0;
      tick();
      check("rx_pop_pulse", rx_pop, 0);
      check("idle_sel", io_rd_sel, 0);
      bus_a = 32'h30000;
      tick();
      check("rx_empty_dout", bus_dout, 0);
      check("rx_empty_sel", io_rd_sel, 1);
      check("rx_empty_pop", rx_pop, 0);
      rx_data = 8'h77;
      bus_a = 32'h30008;
      tick();
      check("other_dout", bus_dout, 0);
      check("other_sel", io_rd_sel, 1);
      rx_valid = 1'b1;
      bus_a = 32'h00000;
      tick();
      idle();
      rx_valid = 1'b0;
      check("mem_dout", bus_dout, 0);
      check("mem_sel", io_rd_sel, 0);
      check("mem_pop", rx_pop, 0);

      for (int k = 0; k < 400 && mcnt != 32'hFF; k++) tick();
      check("cnt_wait", mcnt, 32'hFF);
      snap = mcnt;
      for (int i = 0; i < 4; i++) begin
`ifdef IO_CYCLE_SNAPSHOT_EN
         exp_b = snap[8*i +: 8];
`else
         exp_b = mcnt[8*i +: 8];
`endif
         bus_a = 32'h30004 + i;
         tick();
         check("cnt_byte", bus_dout, exp_b);
      end
      idle();

      // fill with the transmitter stalled
      tx_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         wr(32'h30000, 8'h10 + 8'(i - 1));
         check("full_lvl", io_buffer_full, (16 - i) <= 2);
      end
      check("ovf_before", tx_overflow, 0);
      wr(32'h30000, 8'hEE);
      check("ovf_set", tx_overflow, 1);
      tx_ready = 1'b1;
      repeat (20) tick();
      check("drain_txv", tx_valid, 0);
      check("drain_full", io_buffer_full, 0);
      check("ovf_sticky", tx_overflow, 1);
      chk_txq("fill", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15,
                        8'h16, 8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B,
                        8'h1C, 8'h1D, 8'h1E, 8'h1F});

      // CPU frozen: no push, counter held, TX still drains
      tx_ready = 1'b0;
      wr(32'h30000, 8'hA1);
      wr(32'h30000, 8'hA2);
      wr(32'h30000, 8'hA3);
      rdy_in   = 1'b0;
      tx_ready = 1'b1;
      bus_a    = 32'h30000;
      bus_wr   = 1'b1;
      bus_din  = 8'h77;
      repeat (10) tick();
      check("frz_txv", tx_valid, 0);
      check("frz_sel", io_rd_sel, 0);
      chk_txq("frz", '{8'hA1, 8'hA2, 8'hA3});
      bus_wr = 1'b0;
      bus_a  = 32'h30004;
      rdy_in = 1'b1;
      exp_b  = mcnt[7:0];
      tick();
      idle();
      check("frz_cnt", bus_dout, exp_b);
      tick();
      check("frz_nopush", tx_valid, 0);

      tx_ready = 1'b0;
      wr(32'h30000, 8'hB1);
      wr(32'h30000, 8'hB2);
      wr(32'h30000, 8'hB3);
      wr(32'h30004, 8'h55);
      wr(32'h30000, 8'h99);
      check("drain_nodone", prog_done, 0);
      tx_ready = 1'b1;
      for (int k = 0; k < 60 && !prog_done; k++) tick();
      check("stop_done", prog_done, 1);
      check("stop_full", io_buffer_full, 1);
      chk_txq("stop", '{8'hB1, 8'hB2, 8'hB3, 8'h00});
      wr(32'h30000, 8'h66);
      repeat (3) tick();
      check("stop_nowr", tx_valid, 0);
      chk_txq("stop_after", '{});
      rx_valid = 1'b1;
      rx_data  = 8'hC3;
      bus_a    = 32'h30000;
      tick();
      idle();
      rx_valid = 1'b0;
      check("stop_rd", bus_dout, 8'hC3);

      rst_in = 1'b0;
      tick();
      rst_in = 1'b1;
      tick();
      check("rst2_done", prog_done, 0);
      check("rst2_full", io_buffer_full, 0);
      check("rst2_ovf", tx_overflow, 0);
      tx_ready = 1'b0;
      wr(32'h30000, 8'hC1);
      wr(32'h30000, 8'hC2);
      check("mid_txv", tx_valid, 1);
      rst_in = 1'b0;
      #1;
      check("async_txv", tx_valid, 0);
      tick();
      rst_in = 1'b1;
      tick();
      check("flush_txv", tx_valid, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
